// File: rtl/sys_nxn_controller.sv
// rtl/sys_nxn_controller.sv - NxN systolic array sequencer: clear, skewed operand feed, drain, result display
// Every output is a flop loaded from the next-state values, so outputs line up with the state they describe.
module sys_nxn_controller #(
  parameter int N      = 3,
  parameter int K      = 3,
  parameter int ADDR_W = 5,
  parameter int RD_W   = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic                  right,
  input  logic                  left,
  output logic [N*ADDR_W-1:0]   row_addr,
  output logic [N*ADDR_W-1:0]   col_addr,
  output logic [N-1:0]          row_valid,
  output logic [N-1:0]          col_valid,
  output logic                  sys_en,
  output logic                  sys_clr,
  output logic [RD_W-1:0]       buffer_read_addr,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(K + N) + 1;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(K + N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 2);
  localparam logic [RD_W-1:0]  RD_LAST    = RD_W'(N * N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FEED    = 3'd2,
    S_DRAIN   = 3'd3,
    S_DISPLAY = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RD_W-1:0]    rd_q, rd_d;
  logic [N*ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [N*ADDR_W-1:0] col_addr_q, col_addr_d;
  logic [N-1:0]       row_valid_q, row_valid_d;
  logic [N-1:0]       col_valid_q, col_valid_d;
  logic               sys_en_q, sys_en_d;
  logic               sys_clr_q, sys_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      row_addr_q  <= '0;
      col_addr_q  <= '0;
      row_valid_q <= '0;
      col_valid_q <= '0;
      sys_en_q    <= 1'b0;
      sys_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      row_addr_q  <= row_addr_d;
      col_addr_q  <= col_addr_d;
      row_valid_q <= row_valid_d;
      col_valid_q <= col_valid_d;
      sys_en_q    <= sys_en_d;
      sys_clr_q   <= sys_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          rd_d    = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DISPLAY;
          cnt_d   = '0;
          rd_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DISPLAY: begin
        // start wins over navigation; opposing pulses cancel
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          rd_d    = '0;
        end else if (right && !left) begin
          rd_d = (rd_q == RD_LAST) ? '0 : rd_q + RD_W'(1);
        end else if (left && !right) begin
          rd_d = (rd_q == '0) ? RD_LAST : rd_q - RD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rd_d    = '0;
      end
    endcase
  end

  always_comb begin
    row_addr_d  = '0;
    col_addr_d  = '0;
    row_valid_d = '0;
    col_valid_d = '0;
    sys_clr_d   = (state_d == S_CLEAR);
    sys_en_d    = (state_d == S_FEED) || (state_d == S_DRAIN);
    busy_d      = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DISPLAY);
    if (state_d == S_FEED) begin
      // lane i runs i cycles behind lane 0; rows and columns share the skew
      for (int i = 0; i < N; i++) begin
        if ((cnt_d >= CNT_W'(i)) && ((cnt_d - CNT_W'(i)) < CNT_W'(K))) begin
          row_valid_d[i]                 = 1'b1;
          col_valid_d[i]                 = 1'b1;
          row_addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(i * K) + ADDR_W'(cnt_d - CNT_W'(i));
          col_addr_d[i*ADDR_W +: ADDR_W] = ADDR_W'(i * K) + ADDR_W'(cnt_d - CNT_W'(i));
        end
      end
    end
  end

  assign row_addr         = row_addr_q;
  assign col_addr         = col_addr_q;
  assign row_valid        = row_valid_q;
  assign col_valid        = col_valid_q;
  assign sys_en           = sys_en_q;
  assign sys_clr          = sys_clr_q;
  assign buffer_read_addr = rd_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_sys_nxn_controller.sv
// tb/tb_sys_nxn_controller.sv - directed bench for sys_nxn_controller at N=3,K=3 and N=2,K=4
module tb_sys_nxn_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rstb_a, start_a, right_a, left_a;
  logic [14:0] ra_a, ca_a;
  logic [2:0]  rv_a, cv_a;
  logic        en_a, clr_a, busy_a, done_a;
  logic [3:0]  rd_a;

  logic        rstb_b, start_b, right_b, left_b;
  logic [9:0]  ra_b, ca_b;
  logic [1:0]  rv_b, cv_b;
  logic        en_b, clr_b, busy_b, done_b;
  logic [1:0]  rd_b;

  sys_nxn_controller #(.N(3), .K(3), .ADDR_W(5), .RD_W(4)) u_dut_a (
    .clk(clk), .rstb(rstb_a), .start(start_a), .right(right_a), .left(left_a),
    .row_addr(ra_a), .col_addr(ca_a), .row_valid(rv_a), .col_valid(cv_a),
    .sys_en(en_a), .sys_clr(clr_a), .buffer_read_addr(rd_a), .busy(busy_a), .done(done_a)
  );

  sys_nxn_controller #(.N(2), .K(4), .ADDR_W(5), .RD_W(2)) u_dut_b (
    .clk(clk), .rstb(rstb_b), .start(start_b), .right(right_b), .left(left_b),
    .row_addr(ra_b), .col_addr(ca_b), .row_valid(rv_b), .col_valid(cv_b),
    .sys_en(en_b), .sys_clr(clr_b), .buffer_read_addr(rd_b), .busy(busy_b), .done(done_b)
  );

  // hand-derived feed tables: packed slice values {s2,s1,s0} / {s1,s0}
  int fv_a[5] = '{1, 3, 7, 6, 4};
  int fa_a[5] = '{0, 97, 6274, 7328, 8192};
  int fv_b[5] = '{1, 3, 3, 3, 2};
  int fa_b[5] = '{0, 129, 162, 195, 224};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int clr, input int en, input int bsy,
                       input int dn, input int rv, input int ra, input int rd);
    check({tag, " sys_clr"}, 32'(clr_a), clr);
    check({tag, " sys_en"}, 32'(en_a), en);
    check({tag, " busy"}, 32'(busy_a), bsy);
    check({tag, " done"}, 32'(done_a), dn);
    check({tag, " row_valid"}, 32'(rv_a), rv);
    check({tag, " col_valid"}, 32'(cv_a), rv);
    check({tag, " row_addr"}, 32'(ra_a), ra);
    check({tag, " col_addr"}, 32'(ca_a), ra);
    check({tag, " rd_addr"}, 32'(rd_a), rd);
  endtask

  task automatic chk_b(input string tag, input int clr, input int en, input int bsy,
                       input int dn, input int rv, input int ra, input int rd);
    check({tag, " sys_clr"}, 32'(clr_b), clr);
    check({tag, " sys_en"}, 32'(en_b), en);
    check({tag, " busy"}, 32'(busy_b), bsy);
    check({tag, " done"}, 32'(done_b), dn);
    check({tag, " row_valid"}, 32'(rv_b), rv);
    check({tag, " col_valid"}, 32'(cv_b), rv);
    check({tag, " row_addr"}, 32'(ra_b), ra);
    check({tag, " col_addr"}, 32'(ca_b), ra);
    check({tag, " rd_addr"}, 32'(rd_b), rd);
  endtask

  task automatic pulse_a(input logic s, input logic r, input logic l);
    start_a = s; right_a = r; left_a = l;
    @(negedge clk);
    start_a = 1'b0; right_a = 1'b0; left_a = 1'b0;
  endtask

  task automatic pulse_b(input logic s, input logic r, input logic l);
    start_b = s; right_b = r; left_b = l;
    @(negedge clk);
    start_b = 1'b0; right_b = 1'b0; left_b = 1'b0;
  endtask

  initial begin
    rstb_a = 1'b0; start_a = 1'b0; right_a = 1'b0; left_a = 1'b0;
    rstb_b = 1'b0; start_b = 1'b0; right_b = 1'b0; left_b = 1'b0;
    repeat (2) @(negedge clk);
    chk_a("a reset", 0, 0, 0, 0, 0, 0, 0);
    chk_b("b reset", 0, 0, 0, 0, 0, 0, 0);
    rstb_a = 1'b1;
    @(negedge clk);
    chk_a("a idle", 0, 0, 0, 0, 0, 0, 0);

    pulse_a(1'b1, 1'b0, 1'b0);
    chk_a("a clear", 1, 0, 1, 0, 0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      start_a = 1'b0;
      chk_a($sformatf("a feed t%0d", t), 0, 1, 1, 0, fv_a[t], fa_a[t], 0);
      if (t == 2) start_a = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      chk_a($sformatf("a drain %0d", d), 0, 1, 1, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk_a("a display", 0, 0, 0, 1, 0, 0, 0);

    pulse_a(1'b0, 1'b0, 1'b1);
    check("a left wrap", 32'(rd_a), 8);
    pulse_a(1'b0, 1'b1, 1'b0);
    check("a right wrap", 32'(rd_a), 0);
    for (int i = 0; i < 8; i++) pulse_a(1'b0, 1'b1, 1'b0);
    check("a eight rights", 32'(rd_a), 8);
    for (int i = 0; i < 3; i++) pulse_a(1'b0, 1'b0, 1'b1);
    check("a three lefts", 32'(rd_a), 5);
    pulse_a(1'b0, 1'b1, 1'b1);
    check("a both pulses", 32'(rd_a), 5);
    check("a still done", 32'(done_a), 1);

    pulse_a(1'b1, 1'b1, 1'b0);
    chk_a("a restart", 1, 0, 1, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk_a($sformatf("a refeed t%0d", t), 0, 1, 1, 0, fv_a[t], fa_a[t], 0);
    end
    rstb_a = 1'b0;
    @(negedge clk);
    rstb_a = 1'b1;
    chk_a("a abort", 0, 0, 0, 0, 0, 0, 0);
    pulse_a(1'b0, 1'b1, 1'b0);
    pulse_a(1'b0, 1'b1, 1'b0);
    chk_a("a idle nav", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_a("a idle hold", 0, 0, 0, 0, 0, 0, 0);

    rstb_b = 1'b1;
    @(negedge clk);
    pulse_b(1'b1, 1'b0, 1'b0);
    chk_b("b clear", 1, 0, 1, 0, 0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk_b($sformatf("b feed t%0d", t), 0, 1, 1, 0, fv_b[t], fa_b[t], 0);
    end
    @(negedge clk);
    chk_b("b drain", 0, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk_b("b display", 0, 0, 0, 1, 0, 0, 0);
    pulse_b(1'b0, 1'b0, 1'b1);
    check("b left wrap", 32'(rd_b), 3);
    pulse_b(1'b0, 1'b1, 1'b0);
    check("b right wrap", 32'(rd_b), 0);
    for (int i = 0; i < 3; i++) pulse_b(1'b0, 1'b1, 1'b0);
    check("b three rights", 32'(rd_b), 3);
    pulse_b(1'b0, 1'b1, 1'b0);
    check("b wrap again", 32'(rd_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
